// File: rtl/fpu_sched_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fpu_sched_pkg : shared types and helpers for the FPU issue scheduler
// Rev 1.0
// -----------------------------------------------------------------------------
package fpu_sched_pkg;

  // Encodings mirror fpnew_pkg so the scheduler can sit directly on fpnew_top.
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD    = 4'd0,
    FNMSUB   = 4'd1,
    ADD      = 4'd2,
    MUL      = 4'd3,
    DIV      = 4'd4,
    SQRT     = 4'd5,
    SGNJ     = 4'd6,
    MINMAX   = 4'd7,
    CMP      = 4'd8,
    CLASSIFY = 4'd9,
    F2F      = 4'd10,
    F2I      = 4'd11,
    I2F      = 4'd12,
    CPKAB    = 4'd13,
    CPKCD    = 4'd14
  } operation_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef struct packed {
    roundmode_e  rnd_mode;
    operation_e  op;
    logic        op_mod;
    fp_format_e  src_fmt;
    fp_format_e  dst_fmt;
    int_format_e int_fmt;
    logic        vectorial_op;
  } fpu_req_ctrl_t;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_issue_scheduler_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fpu_issue_scheduler_if : requester, FPU and response bundle of the scheduler
// Rev 1.0
// -----------------------------------------------------------------------------
interface fpu_issue_scheduler_if
  import fpu_sched_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int WIDTH    = 32,
  parameter int ID_WIDTH = id_width(NUM_REQ)
);

  logic          [NUM_REQ-1:0]                  req_valid_i;
  logic          [NUM_REQ-1:0]                  req_ready_o;
  logic          [NUM_REQ-1:0][2:0][WIDTH-1:0]  req_operands_i;
  fpu_req_ctrl_t [NUM_REQ-1:0]                  req_ctrl_i;
  logic                                         flush_i;

  logic                                         fpu_in_valid_o;
  logic                                         fpu_in_ready_i;
  logic          [2:0][WIDTH-1:0]               fpu_operands_o;
  fpu_req_ctrl_t                                fpu_ctrl_o;
  logic          [ID_WIDTH-1:0]                 fpu_tag_o;
  logic                                         fpu_flush_o;

  logic                                         fpu_out_valid_i;
  logic                                         fpu_out_ready_o;
  logic          [WIDTH-1:0]                    fpu_result_i;
  status_t                                      fpu_status_i;
  logic          [ID_WIDTH-1:0]                 fpu_tag_i;

  logic          [NUM_REQ-1:0]                  rsp_valid_o;
  logic          [NUM_REQ-1:0]                  rsp_ready_i;
  logic          [WIDTH-1:0]                    rsp_result_o;
  status_t                                      rsp_status_o;
  logic                                         tag_err_o;
  logic                                         busy_o;

  // Scheduler side.
  modport slave (
    input  req_valid_i, req_operands_i, req_ctrl_i, flush_i,
    input  fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
    input  rsp_ready_i,
    output req_ready_o, fpu_in_valid_o, fpu_operands_o, fpu_ctrl_o, fpu_tag_o,
    output fpu_flush_o, fpu_out_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o,
    output tag_err_o, busy_o
  );

  // Requesters plus FPU side.
  modport master (
    output req_valid_i, req_operands_i, req_ctrl_i, flush_i,
    output fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
    output rsp_ready_i,
    input  req_ready_o, fpu_in_valid_o, fpu_operands_o, fpu_ctrl_o, fpu_tag_o,
    input  fpu_flush_o, fpu_out_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o,
    input  tag_err_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/fpu_sched_credit_cnt.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fpu_sched_credit_cnt : saturating up/down in-flight counter for one requester
// Rev 1.0
// -----------------------------------------------------------------------------
module fpu_sched_credit_cnt #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  wire              clk_i,
  input  wire              rst_ni,
  input  wire              inc_i,
  input  wire              dec_i,
  input  wire              clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over any same-cycle handshake; a decrement at zero is dropped.
  always_comb begin : p_next
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_reg
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/fpu_issue_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fpu_issue_scheduler : round-robin, credit-limited sharing of one FPU
// Rev 1.0
// -----------------------------------------------------------------------------
module fpu_issue_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int WIDTH           = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_WIDTH        = id_width(NUM_REQ)
) (
  input wire                   clk_i,
  input wire                   rst_ni,
  fpu_issue_scheduler_if.slave bus
);

  localparam int                CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ID_WIDTH:0] C_NUM_REQ = (ID_WIDTH + 1)'(NUM_REQ);

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  full;
  logic [NUM_REQ-1:0]  nonzero;
  logic [NUM_REQ-1:0]  req_ready;
  logic [NUM_REQ-1:0]  rsp_valid;
  logic [NUM_REQ-1:0]  tag_sel;
  logic [NUM_REQ-1:0]  inc;
  logic [NUM_REQ-1:0]  dec;

  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] grant_next;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] locked_idx_q, locked_idx_d;
  logic                lock_q, lock_d;
  logic                tag_err_q, tag_err_d;

  logic                in_valid;
  logic                issue_hs;
  logic                tag_ok;
  logic                found;
  int                  scan_idx;

  // First eligible index at or after rr_ptr; a held lock overrides the scan.
  always_comb begin : p_grant
    grant    = rr_ptr_q;
    found    = 1'b0;
    scan_idx = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = (int'(rr_ptr_q) + off) % NUM_REQ;
      if (!found && eligible[scan_idx]) begin
        grant = ID_WIDTH'(scan_idx);
        found = 1'b1;
      end
    end
    if (lock_q) begin
      grant = locked_idx_q;
    end
  end

  assign grant_next = ID_WIDTH'((int'(grant) + 1) % NUM_REQ);
  assign in_valid   = (|eligible) | lock_q;
  assign issue_hs   = in_valid & bus.fpu_in_ready_i;
  assign tag_ok     = ({1'b0, bus.fpu_tag_i} < C_NUM_REQ);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    localparam logic [ID_WIDTH-1:0] C_IDX = ID_WIDTH'(i);

    logic [CNT_W-1:0] cnt;

    assign eligible[i]  = bus.req_valid_i[i] & ~full[i];
    assign req_ready[i] = issue_hs & (grant == C_IDX);
    assign tag_sel[i]   = (bus.fpu_tag_i == C_IDX);
    assign rsp_valid[i] = bus.fpu_out_valid_i & tag_ok & tag_sel[i];
    assign inc[i]       = req_ready[i];
    assign dec[i]       = rsp_valid[i] & bus.rsp_ready_i[i];
    assign nonzero[i]   = |cnt;

    fpu_sched_credit_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
    ) u_credit (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (inc[i]),
      .dec_i  (dec[i]),
      .clr_i  (bus.flush_i),
      .cnt_o  (cnt),
      .full_o (full[i])
    );
  end

  // A flush cycle drops the lock and keeps rr_ptr where it was.
  always_comb begin : p_next
    lock_d       = in_valid & ~bus.fpu_in_ready_i & ~bus.flush_i;
    locked_idx_d = (in_valid & ~bus.fpu_in_ready_i) ? grant : locked_idx_q;
    rr_ptr_d     = (issue_hs & ~bus.flush_i) ? grant_next : rr_ptr_q;
    tag_err_d    = tag_err_q | (bus.fpu_out_valid_i & ~tag_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_reg
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      locked_idx_q <= '0;
      lock_q       <= 1'b0;
      tag_err_q    <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      locked_idx_q <= locked_idx_d;
      lock_q       <= lock_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign bus.req_ready_o     = req_ready;
  assign bus.fpu_in_valid_o  = in_valid;
  assign bus.fpu_operands_o  = bus.req_operands_i[grant];
  assign bus.fpu_ctrl_o      = bus.req_ctrl_i[grant];
  assign bus.fpu_tag_o       = grant;
  assign bus.fpu_flush_o     = bus.flush_i;

  // Results with an unknown tag are swallowed so the FPU never stalls on them.
  assign bus.fpu_out_ready_o = tag_ok ? |(tag_sel & bus.rsp_ready_i) : 1'b1;
  assign bus.rsp_valid_o     = rsp_valid;
  assign bus.rsp_result_o    = bus.fpu_result_i;
  assign bus.rsp_status_o    = bus.fpu_status_i;
  assign bus.tag_err_o       = tag_err_q;
  assign bus.busy_o          = |nonzero;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fpu_issue_scheduler : directed vector table plus corner sequences
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_fpu_issue_scheduler;
  import fpu_sched_pkg::*;

  localparam int N2   = 2;
  localparam int N3   = 3;
  localparam int W    = 32;
  localparam int MAXO = 4;
  localparam int NV   = 34;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_issue_scheduler_if #(.NUM_REQ(N2), .WIDTH(W)) bus2 ();
  fpu_issue_scheduler_if #(.NUM_REQ(N3), .WIDTH(W)) bus3 ();

  fpu_issue_scheduler #(.NUM_REQ(N2), .WIDTH(W), .MAX_OUTSTANDING(MAXO)) dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus2.slave)
  );

  fpu_issue_scheduler #(.NUM_REQ(N3), .WIDTH(W), .MAX_OUTSTANDING(MAXO)) dut3 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus3.slave)
  );

  typedef struct packed {
    logic [1:0] rv;
    logic       ir;
    logic       ov;
    logic       ot;
    logic [1:0] rr;
    logic       fl;
    logic       e_iv;
    logic [1:0] e_rq;
    logic       e_tg;
    logic       e_ordy;
    logic [1:0] e_rspv;
    logic       e_busy;
  } vec_t;

  vec_t                   vecs [NV];
  logic [1:0][2:0][W-1:0] ops2;
  fpu_req_ctrl_t [1:0]    ctl2;
  int                     checks   = 0;
  int                     failures = 0;

  function automatic vec_t mk(
    input logic [1:0] rv, input logic ir, input logic ov, input logic ot,
    input logic [1:0] rr, input logic fl, input logic iv, input logic [1:0] rq,
    input logic tg, input logic ordy, input logic [1:0] rspv, input logic busy);
    vec_t v;
    v.rv = rv; v.ir = ir; v.ov = ov; v.ot = ot; v.rr = rr; v.fl = fl;
    v.e_iv = iv; v.e_rq = rq; v.e_tg = tg; v.e_ordy = ordy; v.e_rspv = rspv; v.e_busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // rv ir ov ot rr fl | iv rq tg ordy rspv busy
    vecs[0]  = mk(2'b00,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b0,2'b00,1'b0,1'b0,2'b00,1'b0);
    vecs[1]  = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b01,1'b0,1'b0,2'b00,1'b0);
    vecs[2]  = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b10,1'b1,1'b0,2'b00,1'b1);
    vecs[3]  = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b01,1'b0,1'b0,2'b00,1'b1);
    vecs[4]  = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b10,1'b1,1'b0,2'b00,1'b1);
    vecs[5]  = mk(2'b11,1'b0,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b00,1'b0,1'b0,2'b00,1'b1);
    vecs[6]  = mk(2'b11,1'b0,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b00,1'b0,1'b0,2'b00,1'b1);
    vecs[7]  = mk(2'b11,1'b0,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b00,1'b0,1'b0,2'b00,1'b1);
    vecs[8]  = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b01,1'b0,1'b0,2'b00,1'b1);
    vecs[9]  = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b10,1'b1,1'b0,2'b00,1'b1);
    vecs[10] = mk(2'b10,1'b0,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b00,1'b1,1'b0,2'b00,1'b1);
    vecs[11] = mk(2'b11,1'b0,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b00,1'b1,1'b0,2'b00,1'b1);
    vecs[12] = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b10,1'b1,1'b0,2'b00,1'b1);
    vecs[13] = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b01,1'b0,1'b0,2'b00,1'b1);
    vecs[14] = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b0,2'b00,1'b1,1'b0,2'b00,1'b1);
    vecs[15] = mk(2'b00,1'b1,1'b1,1'b1,2'b01,1'b0, 1'b0,2'b00,1'b1,1'b0,2'b10,1'b1);
    vecs[16] = mk(2'b00,1'b1,1'b1,1'b1,2'b11,1'b0, 1'b0,2'b00,1'b1,1'b1,2'b10,1'b1);
    vecs[17] = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b10,1'b1,1'b0,2'b00,1'b1);
    vecs[18] = mk(2'b11,1'b1,1'b1,1'b0,2'b01,1'b0, 1'b0,2'b00,1'b0,1'b1,2'b01,1'b1);
    vecs[19] = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b01,1'b0,1'b0,2'b00,1'b1);
    vecs[20] = mk(2'b00,1'b1,1'b1,1'b0,2'b11,1'b0, 1'b0,2'b00,1'b1,1'b1,2'b01,1'b1);
    vecs[21] = mk(2'b00,1'b1,1'b1,1'b0,2'b11,1'b0, 1'b0,2'b00,1'b1,1'b1,2'b01,1'b1);
    vecs[22] = mk(2'b01,1'b1,1'b1,1'b0,2'b01,1'b0, 1'b1,2'b01,1'b0,1'b1,2'b01,1'b1);
    vecs[23] = mk(2'b01,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b01,1'b0,1'b0,2'b00,1'b1);
    vecs[24] = mk(2'b01,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b01,1'b0,1'b0,2'b00,1'b1);
    vecs[25] = mk(2'b01,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b0,2'b00,1'b1,1'b0,2'b00,1'b1);
    vecs[26] = mk(2'b00,1'b1,1'b0,1'b0,2'b00,1'b1, 1'b0,2'b00,1'b1,1'b0,2'b00,1'b1);
    vecs[27] = mk(2'b00,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b0,2'b00,1'b1,1'b0,2'b00,1'b0);
    vecs[28] = mk(2'b11,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b10,1'b1,1'b0,2'b00,1'b0);
    vecs[29] = mk(2'b01,1'b0,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b00,1'b0,1'b0,2'b00,1'b1);
    vecs[30] = mk(2'b10,1'b0,1'b0,1'b0,2'b00,1'b1, 1'b1,2'b00,1'b0,1'b0,2'b00,1'b1);
    vecs[31] = mk(2'b10,1'b0,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b00,1'b1,1'b0,2'b00,1'b0);
    vecs[32] = mk(2'b10,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b1,2'b10,1'b1,1'b0,2'b00,1'b0);
    vecs[33] = mk(2'b00,1'b1,1'b0,1'b0,2'b00,1'b0, 1'b0,2'b00,1'b0,1'b0,2'b00,1'b1);

    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 3; j++)
        ops2[r][j] = 32'h1000_0000 * 32'(r + 1) + 32'(j);
    ctl2[0] = '{rnd_mode: RTZ, op: ADD, op_mod: 1'b0, src_fmt: FP32, dst_fmt: FP32,
                int_fmt: INT32, vectorial_op: 1'b0};
    ctl2[1] = '{rnd_mode: RUP, op: MUL, op_mod: 1'b1, src_fmt: FP64, dst_fmt: FP16,
                int_fmt: INT64, vectorial_op: 1'b1};

    bus2.req_valid_i = '0; bus2.req_operands_i = ops2; bus2.req_ctrl_i = ctl2;
    bus2.flush_i = 1'b0; bus2.fpu_in_ready_i = 1'b0; bus2.fpu_out_valid_i = 1'b0;
    bus2.fpu_result_i = '0; bus2.fpu_status_i = 5'b10101; bus2.fpu_tag_i = '0;
    bus2.rsp_ready_i = '0;
    bus3.req_valid_i = '0; bus3.req_operands_i = '0; bus3.req_ctrl_i = '0;
    bus3.flush_i = 1'b0; bus3.fpu_in_ready_i = 1'b0; bus3.fpu_out_valid_i = 1'b0;
    bus3.fpu_result_i = '0; bus3.fpu_status_i = '0; bus3.fpu_tag_i = '0;
    bus3.rsp_ready_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_valid", 128'(bus2.fpu_in_valid_o), 128'(1'b0));
    chk("rst rsp_valid", 128'(bus2.rsp_valid_o), 128'(2'b00));
    chk("rst busy", 128'(bus2.busy_o), 128'(1'b0));
    chk("rst tag_err", 128'(bus3.tag_err_o), 128'(1'b0));
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      bus2.req_valid_i     = vecs[k].rv;
      bus2.fpu_in_ready_i  = vecs[k].ir;
      bus2.fpu_out_valid_i = vecs[k].ov;
      bus2.fpu_tag_i       = vecs[k].ot;
      bus2.rsp_ready_i     = vecs[k].rr;
      bus2.flush_i         = vecs[k].fl;
      bus2.fpu_result_i    = 32'hC0DE_0000 | 32'(k);
      @(negedge clk);
      chk($sformatf("v%0d in_valid", k), 128'(bus2.fpu_in_valid_o), 128'(vecs[k].e_iv));
      chk($sformatf("v%0d req_ready", k), 128'(bus2.req_ready_o), 128'(vecs[k].e_rq));
      chk($sformatf("v%0d tag", k), 128'(bus2.fpu_tag_o), 128'(vecs[k].e_tg));
      chk($sformatf("v%0d out_ready", k), 128'(bus2.fpu_out_ready_o), 128'(vecs[k].e_ordy));
      chk($sformatf("v%0d rsp_valid", k), 128'(bus2.rsp_valid_o), 128'(vecs[k].e_rspv));
      chk($sformatf("v%0d busy", k), 128'(bus2.busy_o), 128'(vecs[k].e_busy));
      chk($sformatf("v%0d flush", k), 128'(bus2.fpu_flush_o), 128'(vecs[k].fl));
      if (vecs[k].e_iv) begin
        chk($sformatf("v%0d operands", k), 128'(bus2.fpu_operands_o), 128'(ops2[vecs[k].e_tg]));
        chk($sformatf("v%0d ctrl", k), 128'(bus2.fpu_ctrl_o), 128'(ctl2[vecs[k].e_tg]));
      end
      if (vecs[k].ov) begin
        chk($sformatf("v%0d result", k), 128'(bus2.rsp_result_o), 128'(32'hC0DE_0000 | 32'(k)));
        chk($sformatf("v%0d status", k), 128'(bus2.rsp_status_o), 128'(5'b10101));
      end
    end

    // Three requesters: rotation 0,1,2, then an out-of-range tag
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus3.req_valid_i = 3'b111; bus3.fpu_in_ready_i = 1'b1;
      @(negedge clk);
      chk($sformatf("n3 rr%0d tag", k), 128'(bus3.fpu_tag_o), 128'(k));
      chk($sformatf("n3 rr%0d ready", k), 128'(bus3.req_ready_o), 128'(3'b001 << k));
    end
    @(posedge clk); #1;
    bus3.req_valid_i = 3'b000; bus3.fpu_out_valid_i = 1'b1; bus3.fpu_tag_i = 2'd3;
    bus3.rsp_ready_i = 3'b000;
    @(negedge clk);
    chk("n3 badtag out_ready", 128'(bus3.fpu_out_ready_o), 128'(1'b1));
    chk("n3 badtag rsp_valid", 128'(bus3.rsp_valid_o), 128'(3'b000));
    chk("n3 badtag err before edge", 128'(bus3.tag_err_o), 128'(1'b0));
    @(posedge clk); #1;
    bus3.fpu_out_valid_i = 1'b0; bus3.fpu_tag_i = 2'd0;
    @(negedge clk);
    chk("n3 tag_err set", 128'(bus3.tag_err_o), 128'(1'b1));
    @(posedge clk); #1;
    bus3.flush_i = 1'b1;
    @(negedge clk);
    chk("n3 flush out", 128'(bus3.fpu_flush_o), 128'(1'b1));
    chk("n3 busy pre-flush", 128'(bus3.busy_o), 128'(1'b1));
    @(posedge clk); #1;
    bus3.flush_i = 1'b0;
    @(negedge clk);
    chk("n3 tag_err sticky", 128'(bus3.tag_err_o), 128'(1'b1));
    chk("n3 busy after flush", 128'(bus3.busy_o), 128'(1'b0));

    // Asynchronous reset during a stalled request
    @(posedge clk); #1;
    bus2.req_valid_i = 2'b01; bus2.fpu_in_ready_i = 1'b0;
    bus2.fpu_out_valid_i = 1'b0; bus2.rsp_ready_i = 2'b00;
    @(negedge clk);
    chk("stall in_valid", 128'(bus2.fpu_in_valid_o), 128'(1'b1));
    chk("stall busy", 128'(bus2.busy_o), 128'(1'b1));
    @(posedge clk); #1;
    bus2.req_valid_i = 2'b00;
    @(negedge clk);
    chk("stall lock holds", 128'(bus2.fpu_in_valid_o), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("async rst in_valid", 128'(bus2.fpu_in_valid_o), 128'(1'b0));
    chk("async rst busy", 128'(bus2.busy_o), 128'(1'b0));
    chk("async rst tag_err", 128'(bus3.tag_err_o), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_issue_scheduler.md
Name: fpu_issue_scheduler

Overview:
- Shares one fpnew_top instance between NumReq independent requesters, for example integer pipeline, vector sequencer and debug module.
- Arbitrates issue round-robin and stamps the requester ID into the FPU tag.
- Routes each result back to its requester by tag.
- Enforces a per-requester outstanding-operation credit limit so that no requester can saturate the FPU pipeline.

Parameters:
- NumReq, 2, number of requesters (2..8).
- Width, 32, FP operand/result width; equals the FPU Width feature.
- MaxOutstanding, 4, maximum in-flight operations per requester (1..15).
- IdWidth, derived, max(1, $clog2(NumReq)); width of the tag carried through the FPU.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NumReq  per-requester operation valid.
- req_ready_o  out  NumReq  per-requester operation accepted.
- req_operands_i  in  NumReq x 3 x Width  operand triplets.
- req_ctrl_i  in  NumReq x fpu_req_ctrl_t  rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt, vectorial_op.
- flush_i  in  1  kill all in-flight work.
- fpu_in_valid_o  out  1  FPU input valid.
- fpu_in_ready_i  in  1  FPU input ready; may depend combinationally on fpu_in_valid_o.
- fpu_operands_o  out  3 x Width  muxed operands.
- fpu_ctrl_o  out  fpu_req_ctrl_t  muxed control.
- fpu_tag_o  out  IdWidth  granted requester ID.
- fpu_flush_o  out  1  flush to FPU.
- fpu_out_valid_i  in  1  FPU result valid.
- fpu_out_ready_o  out  1  FPU result ready.
- fpu_result_i  in  Width  FPU result.
- fpu_status_i  in  status_t  FPU flags.
- fpu_tag_i  in  IdWidth  returned requester ID.
- rsp_valid_o  out  NumReq  one-hot response valid.
- rsp_ready_i  in  NumReq  per-requester response ready.
- rsp_result_o  out  Width  result, broadcast to all requesters.
- rsp_status_o  out  status_t  status, broadcast to all requesters.
- tag_err_o  out  1  sticky flag: a result returned with an ID >= NumReq.
- busy_o  out  1  any credit counter is non-zero.

Behaviour:
- Reset:
  - All counters = 0; rr_ptr = 0; lock = 0; tag_err_o = 0.
  - All outputs are combinational from these registers, so after reset: fpu_in_valid_o = 0, rsp_valid_o = 0, busy_o = 0.
- Eligibility: requester i is eligible iff req_valid_i[i] && cnt[i] != MaxOutstanding.
- Arbitration:
  - Combinational grant to the first eligible index at or after rr_ptr, wrapping modulo NumReq.
  - fpu_in_valid_o = any eligible, or lock held.
  - Muxed operands, ctrl and tag come from the granted index.
- Stability (AXI rules): if fpu_in_valid_o && !fpu_in_ready_i, register lock = 1 and locked_idx = grant. While locked, the grant is forced to locked_idx regardless of other requests. Requesters are required to hold valid and data stable while waiting.
- Issue handshake (fpu_in_valid_o && fpu_in_ready_i):
  - req_ready_o[grant] = 1 in the same cycle; all other req_ready_o bits = 0.
  - rr_ptr <= grant+1 mod NumReq; lock <= 0.
- Issue latency: 0 cycles, combinational pass-through; no storage on the issue path.
- Response routing:
  - If fpu_tag_i < NumReq: rsp_valid_o[fpu_tag_i] = fpu_out_valid_i and fpu_out_ready_o = rsp_ready_i[fpu_tag_i].
  - Otherwise: fpu_out_ready_o = 1, the result is dropped, and tag_err_o is set (sticky until reset).
- Credits:
  - cnt[i] increments on issue of i and decrements on a response handshake for i.
  - Both in the same cycle: cnt[i] unchanged.
  - Counter width is $clog2(MaxOutstanding+1).
  - A decrement at 0 is an error case and saturates at 0. An increment at MaxOutstanding cannot occur because eligibility blocks it.
- Flush:
  - fpu_flush_o = flush_i.
  - In the flush cycle all counters clear to 0 next edge and lock clears; the issue and response handshakes of that cycle are ignored for counting.
  - rr_ptr is retained; tag_err_o is retained.
- Reset asserted mid-operation: all state returns immediately to reset values; no responses are generated for lost operations.
- NumReq = 1: arbitration degenerates to pass-through; fpu_tag_o = 0.

Decomposition:
- Shared package fpu_sched_pkg holds:
  - fpu_req_ctrl_t, a packed struct of the fpnew_pkg roundmode_e, operation_e, op_mod, fp_format_e x2, int_format_e and vectorial fields;
  - a helper function id_width(NumReq).
- status_t is reused from fpnew_pkg.
- One sub-module, fpu_sched_credit_cnt: a single saturating up/down counter with inc/dec/clr inputs and a full output, instantiated NumReq times.
- The round-robin selector is inline logic, not the shared rr_arb_tree, because the lock and credit gating must be visible to it.

Test Plan:
- Contention: NumReq=2, both valid continuously, fpu_in_ready_i=1 -> grants alternate 0,1,0,1; fpu_tag_o matches; each req_ready_o is one-hot per cycle.
- Backpressure: req0 and req1 both valid with fpu_in_ready_i=0 for 3 cycles -> grant stays on the initially granted index for all 3 cycles and its operands are stable. Raising ready -> that request issues and rr_ptr advances.
- Credit limit: MaxOutstanding=4, req0 issues 4 with no responses -> 5th stalls (req_ready_o[0]=0) while req1 still issues. One tag=0 response handshake -> req0 issues the next cycle.
- Response routing: fpu_out_valid_i=1 with tag 1, rsp_ready_i=2'b01 -> rsp_valid_o=2'b10, fpu_out_ready_o=0. Raising rsp_ready_i[1] -> handshake completes and cnt[1] decrements.
- Simultaneous issue and response: req0 issues and a tag-0 response completes in the same cycle, cnt[0]=2 -> cnt[0] stays 2. Bad tag: NumReq=3, tag=3 -> fpu_out_ready_o=1 and tag_err_o=1 sticky.
- Flush: 3 outstanding across requesters, pulse flush_i -> fpu_flush_o=1, all counters 0 next cycle, busy_o=0, lock cleared. Async reset mid-stall -> fpu_in_valid_o=0 immediately.
